// File: rtl/proc_defs.sv
// Shared definitions for the ECE352 pipeline back-end: opcodes, register indices,
// decoded-field record and control state encoding.
package proc_defs;

   localparam logic [3:0] I_LOAD  = 4'b0000;
   localparam logic [3:0] I_STORE = 4'b0010;
   localparam logic [3:0] I_ADD   = 4'b0100;
   localparam logic [3:0] I_SUB   = 4'b0110;
   localparam logic [3:0] I_NAND  = 4'b1000;
   localparam logic [3:0] I_NOP   = 4'b1010;
   localparam logic [3:0] I_STOP  = 4'b0001;
   localparam logic [2:0] I_SHIFT = 3'b011;
   localparam logic [2:0] I_ORI   = 3'b111;

   localparam int unsigned REG_IDX_W = 2;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // ori always targets and reads this register
   localparam reg_idx_t ORI_REG = 2'b01;

   typedef enum logic [1:0] {
      StRun,
      StDrain,
      StHalted
   } state_e;

   typedef struct packed {
      logic     writes_reg;
      reg_idx_t dest;
      logic     uses_a;
      reg_idx_t src_a;
      logic     uses_b;
      reg_idx_t src_b;
      logic     is_load;
      logic     sets_flags;
      logic     is_store;
      logic     is_stop;
   } fields_t;

   // True when reader rd consumes a register that writer wr will update.
   function automatic logic raw_hit(fields_t rd, fields_t wr);
      return wr.writes_reg &&
             ((rd.uses_a && (rd.src_a == wr.dest)) || (rd.uses_b && (rd.src_b == wr.dest)));
   endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational instruction decode into the fields the control logic needs.
// An invalid slot decodes to all-zero, i.e. a bubble.
module instr_fields
   import proc_defs::*;
#(
   parameter int unsigned INSTR_W = 8
) (
   input  logic               i_valid,
   input  logic [INSTR_W-1:0] i_instr,
   output fields_t            o_fields
);

   logic [3:0] w_op;
   reg_idx_t   w_r1;
   reg_idx_t   w_r2;

   assign w_op = i_instr[3:0];
   assign w_r1 = i_instr[7:6];
   assign w_r2 = i_instr[5:4];

   always_comb begin
      o_fields = '0;
      if (i_valid) begin
         if (w_op[2:0] == I_SHIFT) begin
            o_fields.writes_reg = 1'b1;
            o_fields.dest       = w_r1;
            o_fields.uses_a     = 1'b1;
            o_fields.src_a      = w_r1;
            o_fields.sets_flags = 1'b1;
         end else if (w_op[2:0] == I_ORI) begin
            o_fields.writes_reg = 1'b1;
            o_fields.dest       = ORI_REG;
            o_fields.uses_a     = 1'b1;
            o_fields.src_a      = ORI_REG;
            o_fields.sets_flags = 1'b1;
         end else begin
            case (w_op)
               I_LOAD: begin
                  o_fields.writes_reg = 1'b1;
                  o_fields.dest       = w_r1;
                  o_fields.uses_b     = 1'b1;
                  o_fields.src_b      = w_r2;
                  o_fields.is_load    = 1'b1;
               end
               I_STORE: begin
                  o_fields.uses_a   = 1'b1;
                  o_fields.src_a    = w_r1;
                  o_fields.uses_b   = 1'b1;
                  o_fields.src_b    = w_r2;
                  o_fields.is_store = 1'b1;
               end
               I_ADD, I_SUB, I_NAND: begin
                  o_fields.writes_reg = 1'b1;
                  o_fields.dest       = w_r1;
                  o_fields.uses_a     = 1'b1;
                  o_fields.src_a      = w_r1;
                  o_fields.uses_b     = 1'b1;
                  o_fields.src_b      = w_r2;
                  o_fields.sets_flags = 1'b1;
               end
               I_STOP: o_fields.is_stop = 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/control_write.sv
// Write-side control of the ECE352 pipeline: EX/WB slots, write strobes,
// RAW hazard detection and the stop/drain/halt sequence.
module control_write
   import proc_defs::*;
#(
   parameter bit          WRITE_THROUGH = 1'b0,
   parameter int unsigned INSTR_W       = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [INSTR_W-1:0] i_in_instr,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   output logic               o_rf_write,
   output logic [1:0]         o_rf_wsel,
   output logic               o_wb_src,
   output logic               o_flag_write,
   output logic               o_mem_write,
   output logic [INSTR_W-1:0] o_ir3_out,
   output logic               o_hazard,
   output logic               o_halted
);

   state_e             r_state;
   logic               r_ir3_valid;
   logic [INSTR_W-1:0] r_ir3;
   logic               r_ir4_valid;
   logic [INSTR_W-1:0] r_ir4;

   fields_t w_in_f;
   fields_t w_ir3_f;
   fields_t w_ir4_f;
   logic    w_accept;
   logic    w_live;

   instr_fields #(.INSTR_W(INSTR_W)) u_dec_in (
      .i_valid  (i_in_valid),
      .i_instr  (i_in_instr),
      .o_fields (w_in_f)
   );

   instr_fields #(.INSTR_W(INSTR_W)) u_dec_ir3 (
      .i_valid  (r_ir3_valid),
      .i_instr  (r_ir3),
      .o_fields (w_ir3_f)
   );

   instr_fields #(.INSTR_W(INSTR_W)) u_dec_ir4 (
      .i_valid  (r_ir4_valid),
      .i_instr  (r_ir4),
      .o_fields (w_ir4_f)
   );

   // With a write-through register file the WB slot result is already visible.
   assign o_hazard   = raw_hit(w_in_f, w_ir3_f) | (!WRITE_THROUGH && raw_hit(w_in_f, w_ir4_f));
   assign o_in_ready = (r_state == StRun) && !o_hazard;
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_live     = (r_state != StHalted);

   assign o_rf_write   = w_live && w_ir4_f.writes_reg;
   assign o_rf_wsel    = w_ir4_f.dest;
   assign o_wb_src     = w_live && w_ir4_f.is_load;
   assign o_flag_write = w_live && w_ir4_f.sets_flags;
   assign o_mem_write  = w_live && w_ir3_f.is_store;
   assign o_ir3_out    = r_ir3;
   assign o_halted     = (r_state == StHalted);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= StRun;
         r_ir3_valid <= 1'b0;
         r_ir3       <= '0;
         r_ir4_valid <= 1'b0;
         r_ir4       <= '0;
      end else begin
         if (w_live) begin
            r_ir3_valid <= w_accept;
            r_ir3       <= w_accept ? i_in_instr : '0;
            r_ir4_valid <= r_ir3_valid;
            r_ir4       <= r_ir3;
         end
         unique case (r_state)
            StRun:    if (w_accept && w_in_f.is_stop) r_state <= StDrain;
            StDrain:  if (w_ir4_f.is_stop) r_state <= StHalted;
            StHalted: ;
            default:  r_state <= StRun;
         endcase
      end
   end

endmodule

// File: tb/tb_control_write.sv
// Directed bench for control_write: a per-cycle vector table plus hand sequences
// for stall length and stop-to-halt latency.
module tb_control_write;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ins;
   logic       vld;
   logic       rdy, rfw, wbs, flg, mw, hz, hlt;
   logic [1:0] wsel;
   logic [7:0] ir3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   control_write #(.WRITE_THROUGH(1'b0), .INSTR_W(8)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_in_instr   (ins),
      .i_in_valid   (vld),
      .o_in_ready   (rdy),
      .o_rf_write   (rfw),
      .o_rf_wsel    (wsel),
      .o_wb_src     (wbs),
      .o_flag_write (flg),
      .o_mem_write  (mw),
      .o_ir3_out    (ir3),
      .o_hazard     (hz),
      .o_halted     (hlt)
   );

   typedef struct {
      logic        rst;
      logic        vld;
      logic [7:0]  ins;
      logic        chk;
      logic [16:0] exp;
   } vec_t;

   vec_t vq[$];

   // exp = {ready, hazard, rf_write, wsel, wb_src, flag_write, mem_write, halted, ir3}
   function automatic vec_t mk(logic r, logic v, logic [7:0] i, logic c, logic e_rdy,
                               logic e_hz, logic e_rfw, logic [1:0] e_wsel, logic e_wbs,
                               logic e_flg, logic e_mw, logic e_hlt, logic [7:0] e_ir3);
      vec_t t;
      t.rst = r;
      t.vld = v;
      t.ins = i;
      t.chk = c;
      t.exp = {e_rdy, e_hz, e_rfw, e_wsel, e_wbs, e_flg, e_mw, e_hlt, e_ir3};
      return t;
   endfunction

   function automatic logic [16:0] observed();
      return {rdy, hz, rfw, wsel, wbs, flg, mw, hlt, ir3};
   endfunction

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall;
      int got;
      int cyc;
      int seen_rdy;

      //                rst vld ins   chk rdy hz rfw wsel wbs flg mw hlt ir3
      vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'hB4, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00)); // add R2,R3
      vq.push_back(mk(0, 1, 8'h64, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'hB4)); // add R1,R2 stalls
      vq.push_back(mk(0, 1, 8'h64, 1, 0, 1, 1, 2'd2, 0, 1, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'h64, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h64));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 2'd1, 0, 1, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'h2F, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00)); // ori
      vq.push_back(mk(0, 1, 8'h03, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h2F)); // shift R0
      vq.push_back(mk(0, 1, 8'h43, 1, 0, 1, 1, 2'd1, 0, 1, 0, 0, 8'h03)); // shift R1
      vq.push_back(mk(0, 1, 8'h43, 1, 1, 0, 1, 2'd0, 0, 1, 0, 0, 8'h00));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h43));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 2'd1, 0, 1, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'h10, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00)); // load R0,[R1]
      vq.push_back(mk(0, 1, 8'h12, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h10)); // store R0,[R1]
      vq.push_back(mk(0, 1, 8'h12, 1, 0, 1, 1, 2'd0, 1, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'h12, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 2'd0, 0, 0, 1, 0, 8'h12));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'hB4, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00)); // add, stop, add
      vq.push_back(mk(0, 1, 8'h01, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'hB4));
      vq.push_back(mk(0, 1, 8'h14, 1, 0, 0, 1, 2'd2, 0, 1, 0, 0, 8'h01));
      vq.push_back(mk(0, 1, 8'h14, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'h14, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00));
      vq.push_back(mk(0, 1, 8'h14, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00));
      vq.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00)); // reset from HALTED
      vq.push_back(mk(0, 1, 8'hB4, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 1, 8'h01, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'hB4));
      vq.push_back(mk(1, 0, 8'h00, 1, 0, 0, 1, 2'd2, 0, 1, 0, 0, 8'h01)); // reset in DRAIN
      vq.push_back(mk(0, 1, 8'h14, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h14));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 2'd0, 0, 1, 0, 0, 8'h00));
      vq.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00));

      rst = 1'b1;
      vld = 1'b0;
      ins = 8'h00;
      step();

      for (int k = 0; k < vq.size(); k++) begin
         rst = vq[k].rst;
         vld = vq[k].vld;
         ins = vq[k].ins;
         #1;
         if (vq[k].chk) check($sformatf("vec%0d", k), int'(observed()), int'(vq[k].exp));
         step();
      end

      // Dependent add must stall exactly two cycles with no write-through.
      rst = 1'b0;
      vld = 1'b1;
      ins = 8'hB4;
      #1;
      check("seq_first_accept", int'(rdy), 1);
      step();
      ins   = 8'h64;
      stall = 0;
      got   = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         #1;
         if (rdy) got = 1;
         else begin
            stall++;
            step();
         end
      end
      check("seq_stall_bound", got, 1);
      check("seq_stall_cycles", stall, 2);
      step();
      vld = 1'b0;
      repeat (3) step();

      // Stop accepted, then halted appears in the third cycle after acceptance.
      vld = 1'b1;
      ins = 8'h01;
      #1;
      check("seq_stop_accept", int'(rdy), 1);
      step();
      ins      = 8'hB4;
      cyc      = 1;
      got      = 0;
      seen_rdy = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         #1;
         if (rdy) seen_rdy = 1;
         if (hlt) got = 1;
         else begin
            cyc++;
            step();
         end
      end
      check("seq_halt_bound", got, 1);
      check("seq_halt_latency", cyc, 3);
      check("seq_drain_no_accept", seen_rdy, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         #1;
         check($sformatf("seq_halt_hold%0d", c), int'({rdy, rfw, flg, mw, hlt}), 5'b00001);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
